parity_stim_checker: RTL
========================

// Module: parity_stim_checker
// PURPOSE
//  Self-running stimulus/check stage directly upstream of the 3-input parity gate under test.
//  Drives every a/b/c combination in turn, waits for the gate to settle, samples its w output.
//  Compares w against the expected parity and counts mismatches.
//  Replaces hand-written #delay vector lists with a synthesizable, clocked sequencer.
// PARAMETERS
//  SETTLE_CYCLES  2  cycles a vector is held before w is sampled; legal range >=1
//  EXPECT_ODD     1  1: expected w = a^b^c; 0: expected w = ~(a^b^c)
//  LOOPS          1  number of full 8-vector sweeps per run; legal range >=1
//  ERR_W          4  width of err_count; the count saturates
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  rst        in   1      reset: synchronous, active-high
//  start      in   1      starts a run; sampled only in IDLE
//  w          in   1      response from the gate under test
//  a, b, c    out  1 each vector bits to the gate under test, registered; a = MSB
//  busy       out  1      high in APPLY/WAIT/CHECK
//  done       out  1      one-cycle pulse at end of run
//  err_count  out  ERR_W  mismatches this run, saturating
//  pass       out  1      err_count==0 at end of run; held until the next start
// BEHAVIOUR
//  Reset values: a=b=c=0, busy=0, done=0, err_count=0, pass=0, FSM in IDLE.
//  FSM IDLE -> APPLY -> WAIT -> CHECK -> {APPLY | DONE} -> IDLE.
//  IDLE: start=1 clears err_count and pass, clears vec/loop counters, next state APPLY.
//  APPLY (1 cycle): {a,b,c} <= vec. The new values are visible on the ports from the next cycle.
//  WAIT: stays exactly SETTLE_CYCLES cycles (timer counts 0..SETTLE_CYCLES-1).
//  CHECK (1 cycle): samples w and compares it with expected(vec).
//   On mismatch: err_count++ unless it is already at 2^ERR_W-1.
//   If vec==7 and this is the last loop: DONE. Otherwise vec wraps 7->0 (and the loop counter increments), then APPLY.
//  Vector order is ascending 3'b000..3'b111 in every loop.
//  DONE (1 cycle): done=1; pass <= (final err_count==0); a=b=c <= 0; next state IDLE.
//  Cycles per vector = SETTLE_CYCLES+2.
//  done is high in cycle 8*LOOPS*(SETTLE_CYCLES+2)+1, counting the cycle start was sampled as cycle 0.
//  Boundaries:
//   start while busy or in DONE: ignored, with no effect on the run.
//   rst mid-run: immediate return to reset values; no done pulse; err_count is lost.
//   err_count saturates and never wraps.
//   w is sampled only in CHECK; w glitches in other states are ignored.
//   start held high continuously: a new run begins in the IDLE cycle after each DONE.
// CONFIGURATION
//  Macro PARITY_FAIL_CAPTURE_EN.
//  Defined: adds output fail_vec (3 bits) and output fail_valid (1 bit), both reset to 0.
//   Both are cleared on an accepted start.
//   On the first mismatch of a run: fail_vec <= vec and fail_valid <= 1.
//   Later mismatches in the same run do not change them.
//  Undefined: neither port exists and no capture logic is built; all other behaviour is identical.
// STRUCTURE
//  Package parity_chk_pkg holds:
//   - VEC_W = 3
//   - typedef enum logic [2:0] state_t {IDLE, APPLY, WAIT, CHECK, DONE}
//   - function expected_bit(vec, odd)
//  Sub-module settle_timer: load/count/expire pulse, parameterised by SETTLE_CYCLES.
//  The FSM, counters and compare logic stay in parity_stim_checker.
// TESTING
//  1 Model w=a^b^c combinationally; defaults; pulse start.
//    -> done in cycle 33; err_count=0; pass=1; a,b,c step through 000..111 every 4 cycles.
//  2 Tie w=0; defaults.
//    -> err_count=4 (vectors 001, 010, 100, 111); pass=0.
//    -> With PARITY_FAIL_CAPTURE_EN: fail_vec=3'b001 and fail_valid=1.
//  3 Model w=~(a^b^c); EXPECT_ODD=0.
//    -> err_count=0; pass=1. The same model with EXPECT_ODD=1 gives err_count=8.
//  4 Extra start pulse at cycle 10 -> ignored; done still at cycle 33.
//    Separate run with rst at cycle 12 -> next cycle busy=0, a=b=c=0, and done never pulses.
//  5 ERR_W=2, LOOPS=2, w tied 0.
//    -> 8 raw mismatches; err_count saturates at 3; done in cycle 65; pass=0.
//  6 SETTLE_CYCLES=1; w model delays parity by 2 cycles.
//    -> err_count>0. Same model with SETTLE_CYCLES=3 -> err_count=0.

Source files
------------

// File: rtl/parity_chk_pkg.sv
// Shared definitions for the parity gate stimulus/check stage.
//   VEC_W        width of the a/b/c stimulus vector
//   VEC_LAST     last vector of a sweep (3'b111)
//   state_t      sequencer states
//   expected_bit reference parity for a vector, odd or even sense
package parity_chk_pkg;

  localparam int unsigned VEC_W = 3;
  localparam logic [VEC_W-1:0] VEC_LAST = '1;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    WAIT,
    CHECK,
    DONE
  } state_t;

  // odd=1: w should equal a^b^c; odd=0: w should equal its complement.
  function automatic logic expected_bit(input logic [VEC_W-1:0] vec, input logic odd);
    return odd ? ^vec : ~^vec;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Settle timer: counts SETTLE_CYCLES cycles after a load pulse.
//   clk     clock, all state on posedge
//   rst     synchronous active-high reset
//   load    restart the count from 0 (counting begins the following cycle)
//   expire  high in the final counted cycle (count == SETTLE_CYCLES-1)
module settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             active_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (cnt_q == CNT_LAST) begin
        active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign expire = active_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/parity_stim_checker.sv
// Self-running stimulus/check sequencer for a 3-input parity gate.
// Sweeps {a,b,c} through 000..111 LOOPS times, holds each vector SETTLE_CYCLES cycles,
// samples w once per vector and counts mismatches against the expected parity.
//   clk        clock, all state on posedge
//   rst        synchronous active-high reset
//   start      begin a run (only honoured in IDLE)
//   w          response from the gate under test
//   a, b, c    registered stimulus, a = MSB
//   busy       high in APPLY/WAIT/CHECK
//   done       one-cycle pulse at end of run
//   err_count  saturating mismatch count for the current run
//   pass       err_count was zero at end of run; held until next start
// Optional build macro PARITY_FAIL_CAPTURE_EN adds fail_vec/fail_valid, which record the
// first mismatching vector of a run.
module parity_stim_checker
  import parity_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          EXPECT_ODD    = 1'b1,
  parameter int unsigned LOOPS         = 1,
  parameter int unsigned ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             w,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_count,
`ifdef PARITY_FAIL_CAPTURE_EN
  output logic [VEC_W-1:0] fail_vec,
  output logic             fail_valid,
`endif
  output logic             pass
);

  localparam int unsigned LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;
  localparam logic [LOOP_W-1:0] LAST_LOOP = LOOP_W'(LOOPS - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  state_t            state_q;
  logic [VEC_W-1:0]  vec_q;
  logic [LOOP_W-1:0] loop_q;
  logic              timer_load;
  logic              timer_expire;
  logic              mismatch;

  // Timer is loaded in APPLY so its count 0 lines up with the first WAIT cycle.
  assign timer_load = (state_q == APPLY);
  assign mismatch   = (state_q == CHECK) && (w != expected_bit(vec_q, EXPECT_ODD));

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load),
    .expire(timer_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_q     <= '0;
      loop_q    <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      c         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_count <= '0;
      pass      <= 1'b0;
`ifdef PARITY_FAIL_CAPTURE_EN
      fail_vec   <= '0;
      fail_valid <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            err_count <= '0;
            pass      <= 1'b0;
            vec_q     <= '0;
            loop_q    <= '0;
            busy      <= 1'b1;
            state_q   <= APPLY;
`ifdef PARITY_FAIL_CAPTURE_EN
            fail_vec   <= '0;
            fail_valid <= 1'b0;
`endif
          end
        end
        APPLY: begin
          {a, b, c} <= vec_q;
          state_q   <= WAIT;
        end
        WAIT: begin
          if (timer_expire) begin
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (mismatch && (err_count != ERR_MAX)) begin
            err_count <= err_count + 1'b1;
          end
`ifdef PARITY_FAIL_CAPTURE_EN
          if (mismatch && !fail_valid) begin
            fail_vec   <= vec_q;
            fail_valid <= 1'b1;
          end
`endif
          if ((vec_q == VEC_LAST) && (loop_q == LAST_LOOP)) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= DONE;
          end else begin
            // vec wraps 7->0 naturally; the loop counter advances on the wrap.
            vec_q <= vec_q + 1'b1;
            if (vec_q == VEC_LAST) begin
              loop_q <= loop_q + 1'b1;
            end
            state_q <= APPLY;
          end
        end
        DONE: begin
          // err_count already holds the last CHECK's update here.
          pass      <= (err_count == '0);
          {a, b, c} <= '0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
